// File: rtl/board_audio_out.sv
// board_audio_out
//   Board-level audio output stage. Stereo signed PCM pairs enter through a
//   one-entry valid/ready holding register. At every frame start the pair moves
//   into the playing registers. The playing pair is then sent out two ways:
//   as a Philips I2S stream, and as a first-order sigma-delta 1-bit stream per
//   channel.
//
//   Parameters
//     DW        PCM sample width (8..24), signed two's complement
//     SLOT_BITS BCK periods per channel slot (>= DW+1)
//     CLK_DIV   clk_sys cycles per BCK half-period (>= 2)
//
//   Ports
//     clk_sys, reset          clock / async active-high reset
//     sample_l, sample_r      PCM pair from the core
//     sample_valid            pair offered
//     sample_ready            holding register empty
//     I2S_BCK/LRCK/DATA       I2S stream (LRCK 0 = left), MSB first, 1-BCK delay
//     AUDIO_L, AUDIO_R        sigma-delta bitstreams
//     underrun                1-cycle pulse: frame started with nothing buffered
module board_audio_out #(
    parameter int DW        = 16,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [DW-1:0] sample_l,
    input  logic [DW-1:0] sample_r,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic          I2S_BCK,
    output logic          I2S_LRCK,
    output logic          I2S_DATA,
    output logic          AUDIO_L,
    output logic          AUDIO_R,
    output logic          underrun
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = $clog2(DW);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             bck_fall;
    logic             started;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] pos_next;
    logic [BIT_W-1:0] slot_pos;
    logic             in_right;
    logic             frame_start;
    logic             full;
    logic [DW-1:0]    hold_l, hold_r;
    logic [DW-1:0]    play_l, play_r;
    logic [DW-1:0]    cur_sample;
    logic [IDX_W-1:0] bit_idx;
    logic             data_nxt;
    logic [DW-1:0]    u_l, u_r;
    logic [DW:0]      acc_l, acc_r;

    assign div_wrap     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bck_fall     = div_wrap && I2S_BCK;
    assign sample_ready = !full;

    // Position of the falling edge about to happen. The very first falling
    // edge after reset is position 0, so the counter only advances once started.
    always_comb begin
        pos_next = '0;
        if (started)
            pos_next = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + 1'b1;
        in_right   = (pos_next >= BIT_W'(SLOT_BITS));
        slot_pos   = in_right ? pos_next - BIT_W'(SLOT_BITS) : pos_next;
        cur_sample = in_right ? play_r : play_l;
        // Slot position p carries sample bit DW-p (one-BCK delay, MSB first).
        bit_idx    = IDX_W'(DW - int'(slot_pos));
        data_nxt   = 1'b0;
        if (slot_pos >= BIT_W'(1) && slot_pos <= BIT_W'(DW))
            data_nxt = cur_sample[bit_idx];
    end

    assign frame_start = bck_fall && (pos_next == '0);

    // Bit clock, bit counter and the serial outputs. LRCK/DATA only move
    // together with the BCK falling edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            I2S_BCK  <= 1'b0;
            started  <= 1'b0;
            bit_cnt  <= '0;
            I2S_LRCK <= 1'b0;
            I2S_DATA <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                I2S_BCK <= ~I2S_BCK;
            if (bck_fall) begin
                started  <= 1'b1;
                bit_cnt  <= pos_next;
                I2S_LRCK <= in_right;
                I2S_DATA <= data_nxt;
            end
        end
    end

    // Holding and playing registers. A frame start only looks at the
    // registered full flag; a write arriving in an underrun frame-start cycle
    // is simply buffered for the next frame.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            hold_l   <= '0;
            hold_r   <= '0;
            play_l   <= '0;
            play_r   <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_start && !full;
            if (frame_start && full) begin
                play_l <= hold_l;
                play_r <= hold_r;
                full   <= 1'b0;
            end else if (sample_valid && sample_ready) begin
                hold_l <= sample_l;
                hold_r <= sample_r;
                full   <= 1'b1;
            end
        end
    end

    // First-order sigma-delta: the carry out of an offset-binary accumulator
    // is the 1-bit output.
    assign u_l = {~play_l[DW-1], play_l[DW-2:0]};
    assign u_r = {~play_r[DW-1], play_r[DW-2:0]};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc_l   <= '0;
            acc_r   <= '0;
            AUDIO_L <= 1'b0;
            AUDIO_R <= 1'b0;
        end else begin
            acc_l   <= {1'b0, acc_l[DW-1:0]} + {1'b0, u_l};
            acc_r   <= {1'b0, acc_r[DW-1:0]} + {1'b0, u_r};
            AUDIO_L <= acc_l[DW];
            AUDIO_R <= acc_r[DW];
        end
    end

endmodule
